fetch_decode_queue: RTL and testbench
=====================================

# fetch_decode_queue

Parametrised instruction queue between fetch and decode in the MIPS pipeline. It generalises the single IF/ID latch into a DEPTH-entry FIFO of instruction and next-PC pairs, with flush, back-pressure and halt detection. It also extracts the register, shift and immediate fields of the head instruction so decode sees pre-split operands. Fetch pushes on `ihit`; decode pops when it advances.

## Interface
Parameters:
- `WIDTH`, 32: instruction and PC width in bits; must be ≥ 32.
- `DEPTH`, 4: number of entries; power of two, ≥ 2.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `ihit`  in  1  fetch presents a valid instruction this cycle.
- `instr_in`  in  WIDTH  fetched instruction.
- `npc_in`  in  WIDTH  PC+4 of the fetched instruction.
- `flush`  in  1  discard all queued and incoming instructions.
- `pop`  in  1  decode consumes the head entry.
- `ext_op`  in  1  immediate extension mode: 1 = sign-extend, 0 = zero-extend.
- `accept`  out  1  the push this cycle is taken.
- `full`  out  1  `count == DEPTH`.
- `count`  out  $clog2(DEPTH+1)  number of occupied entries.
- `valid`  out  1  head outputs are meaningful.
- `instr`, `npc`  out  WIDTH  head instruction and its PC+4.
- `rs`, `rt`, `rd`  out  5  head bits [25:21], [20:16], [15:11].
- `shamt`  out  WIDTH  head bits [10:6], zero-extended.
- `imm`  out  WIDTH  head bits [15:0], extended per `ext_op`.
- `lui`  out  WIDTH  head bits [15:0] shifted left by 16; lower bits zero.
- `halt`  out  1  `valid` and head opcode [31:26] == 6'b111111.

## Operation
- Storage is a circular buffer with read pointer, write pointer and count. Pointers wrap modulo DEPTH.
- Effective pop: `pop_eff = pop & valid & ~flush`. A `pop` on an empty queue is ignored.
- Push accept: `accept = ihit & ~flush & ~halt_seen & (~full | pop_eff)`. When the queue is full, a simultaneous pop and push both succeed and count stays at DEPTH.
- `halt_seen` is an internal sticky flag. It sets when an accepted instruction has opcode 6'b111111. While it is set, all further `ihit` pushes are refused, so nothing after the halt enters decode. It clears only on `flush` or `RST`.
- `flush` sets count to 0, resets both pointers to 0 and clears `halt_seen` at the clock edge. A push in the same cycle is dropped. `flush` has priority over push and pop.
- Field outputs are purely combinational from the head entry. When `valid` = 0, `instr`, `npc` and all field outputs are 0.
- Count update: +1 on accept without pop_eff, −1 on pop_eff without accept, otherwise unchanged.

## Timing
- Reset state: count = 0, pointers = 0, `halt_seen` = 0. Resulting outputs: `valid` = 0, `full` = 0, `count` = 0, `halt` = 0, all data and field outputs = 0. `accept` follows its equation, so it equals `ihit` while the queue is empty.
- `RST` asserted mid-operation clears all state immediately and asynchronously. Contents are lost.
- Latency without bypass: an instruction accepted at edge N is visible as the head (`valid` = 1) after edge N.
- Entries leave in strict FIFO order. Throughput is one push and one pop per cycle.
- `full` and `count` reflect registered state only. They do not change combinationally with `ihit` or `pop`.

## Configuration
- `FDQ_BYPASS_EN`:
  - Defined: when count = 0 and `ihit & ~flush & ~halt_seen`, the head outputs and `valid` present `instr_in` and `npc_in` combinationally in the same cycle.
    - If `pop` is also high, the instruction is consumed directly and never written. Count stays 0 and the pointers do not move.
    - If `pop` is low, the instruction is stored normally.
  - Undefined: no fall-through path. Minimum latency is one cycle, as described in Timing.

## Test plan
- Reset, then push 0x20010005 (addi r1,r0,5) with `npc_in` = 0x4 → after the edge: `valid` = 1, `rs` = 0, `rt` = 1, `imm` = 0x5, `npc` = 0x4, `count` = 1.
- DEPTH = 4: push 4 instructions with no pop → `full` = 1. A fifth `ihit` gives `accept` = 0. Push with `pop` asserted while full → `accept` = 1, `count` = 4, outputs in FIFO order.
- Head 0x3C01FFFF with `ext_op` = 1 → `imm` = 0xFFFFFFFF and `lui` = 0xFFFF0000. With `ext_op` = 0 → `imm` = 0x0000FFFF.
- Push 0xFC000000, then 0x20010001 → the second push is refused (`accept` = 0). Once the halt word is at the head, `halt` = 1. `flush` → `count` = 0, and a following push is accepted.
- With 3 entries queued, assert `flush` together with `ihit` and `pop` → next cycle `valid` = 0 and `count` = 0. Assert `RST` mid-stream → outputs go to 0 asynchronously.
- With `FDQ_BYPASS_EN`: empty queue, `ihit` + `pop` with 0x00221820 → same-cycle `rd` = 3, `rt` = 2, `rs` = 1, `valid` = 1, and `count` stays 0.

Source files
------------

// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode queue handshake and head-field bundle.
// master drives fetch/decode requests, slave is the queue.
interface fetch_decode_queue_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic                           ihit;
  logic [WIDTH-1:0]               instr_in;
  logic [WIDTH-1:0]               npc_in;
  logic                           flush;
  logic                           pop;
  logic                           ext_op;
  logic                           accept;
  logic                           full;
  logic [$clog2(DEPTH+1)-1:0]     count;
  logic                           valid;
  logic [WIDTH-1:0]               instr;
  logic [WIDTH-1:0]               npc;
  logic [4:0]                     rs;
  logic [4:0]                     rt;
  logic [4:0]                     rd;
  logic [WIDTH-1:0]               shamt;
  logic [WIDTH-1:0]               imm;
  logic [WIDTH-1:0]               lui;
  logic                           halt;

  modport master (
    output ihit, instr_in, npc_in, flush, pop, ext_op,
    input  accept, full, count, valid, instr, npc,
    input  rs, rt, rd, shamt, imm, lui, halt
  );

  modport slave (
    input  ihit, instr_in, npc_in, flush, pop, ext_op,
    output accept, full, count, valid, instr, npc,
    output rs, rt, rd, shamt, imm, lui, halt
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// IF/ID instruction FIFO with flush, halt blocking and field split.
// Define FDQ_BYPASS_EN to let an empty queue fall through same-cycle.
module fetch_decode_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic               CLK,
  input logic               RST,
  fetch_decode_queue_if.slave q
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] npc_mem   [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             halt_seen;

  logic             stored_valid;
  logic             byp;
  logic             byp_take;
  logic             pop_eff;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] head_instr;
  logic [WIDTH-1:0] head_npc;

  assign stored_valid = (cnt != '0);
  assign q.full       = (cnt == CW'(DEPTH));
  assign q.count      = cnt;

`ifdef FDQ_BYPASS_EN
  assign byp = ~stored_valid & q.ihit & ~q.flush & ~halt_seen;
`else
  assign byp = 1'b0;
`endif

  assign q.valid  = stored_valid | byp;
  assign pop_eff  = q.pop & q.valid & ~q.flush;
  assign q.accept = q.ihit & ~q.flush & ~halt_seen
                  & (~q.full | pop_eff);

  // a bypassed word popped in the same cycle is never stored
  assign byp_take = byp & q.pop;
  assign wr_en    = q.accept & ~byp_take;
  assign rd_en    = pop_eff & stored_valid;

  // head select: stored entry, else fall-through word, else zero
  always_comb begin
    head_instr = '0;
    head_npc   = '0;
    if (stored_valid) begin
      head_instr = instr_mem[rd_ptr];
      head_npc   = npc_mem[rd_ptr];
    end else if (byp) begin
      head_instr = q.instr_in;
      head_npc   = q.npc_in;
    end
  end

  assign q.instr = head_instr;
  assign q.npc   = head_npc;
  assign q.rs    = head_instr[25:21];
  assign q.rt    = head_instr[20:16];
  assign q.rd    = head_instr[15:11];
  assign q.shamt = WIDTH'(head_instr[10:6]);
  assign q.imm   = q.ext_op
                 ? {{(WIDTH-16){head_instr[15]}}, head_instr[15:0]}
                 : WIDTH'(head_instr[15:0]);
  assign q.lui   = WIDTH'(head_instr[15:0]) << 16;
  assign q.halt  = q.valid & (head_instr[31:26] == 6'h3f);

  // storage array write; contents need no reset
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      instr_mem[wr_ptr] <= q.instr_in;
      npc_mem[wr_ptr]   <= q.npc_in;
    end
  end

  // pointers, occupancy and sticky halt
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      halt_seen <= 1'b0;
    end else if (q.flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      halt_seen <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        wr_en & ~rd_en: cnt <= cnt + 1'b1;
        rd_en & ~wr_en: cnt <= cnt - 1'b1;
        default: ;
      endcase
      if (q.accept && q.instr_in[31:26] == 6'h3f)
        halt_seen <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed testbench for fetch_decode_queue.
// Covers reset, FIFO order, fields, halt, flush, async reset.
module tb_fetch_decode_queue;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int vectors = 0;
  int errors  = 0;

  fetch_decode_queue_if #(.WIDTH(32), .DEPTH(4)) bus();

  fetch_decode_queue #(.WIDTH(32), .DEPTH(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .q(bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.ihit = 0; bus.pop = 0; bus.flush = 0;
  endtask

  task automatic test_reset();
    bus.ihit = 0; bus.pop = 0; bus.flush = 0; bus.ext_op = 1;
    bus.instr_in = 32'h0; bus.npc_in = 32'h0;
    #1 RST = 1;
    #1;
    vectors++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.valid); end
    vectors++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.count); end
    vectors++; if (bus.full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", bus.full); end
    vectors++; if (bus.halt !== 1'b0) begin errors++; $display("FAIL rst_halt got %b exp 0", bus.halt); end
    vectors++; if (bus.instr !== 32'h0 || bus.npc !== 32'h0 || bus.imm !== 32'h0) begin errors++; $display("FAIL rst_data got %h/%h/%h exp 0", bus.instr, bus.npc, bus.imm); end
    bus.ihit = 1;
    #1;
    vectors++; if (bus.accept !== 1'b1) begin errors++; $display("FAIL rst_accept got %b exp 1", bus.accept); end
    bus.ihit = 0;
    tick();
    RST = 0;
    tick();
  endtask

  task automatic test_push_basic();
    bus.ext_op = 1;
    bus.ihit = 1; bus.instr_in = 32'h20010005; bus.npc_in = 32'h4;
    #1;
    vectors++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL basic_no_fallthru got %b exp 0", bus.valid); end
    tick();
    idle();
    #1;
    vectors++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", bus.valid); end
    vectors++; if (bus.rs !== 5'd0 || bus.rt !== 5'd1 || bus.rd !== 5'd0) begin errors++; $display("FAIL basic_regs got %0d/%0d/%0d exp 0/1/0", bus.rs, bus.rt, bus.rd); end
    vectors++; if (bus.imm !== 32'h5) begin errors++; $display("FAIL basic_imm got %h exp 00000005", bus.imm); end
    vectors++; if (bus.npc !== 32'h4) begin errors++; $display("FAIL basic_npc got %h exp 00000004", bus.npc); end
    vectors++; if (bus.count !== 3'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", bus.count); end
    bus.pop = 1;
    tick();
    idle();
    #1;
    vectors++; if (bus.count !== 3'd0 || bus.valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %0d/%b exp 0/0", bus.count, bus.valid); end
  endtask

  task automatic test_full();
    logic [31:0] words [5];
    words[0] = 32'h00000011; words[1] = 32'h00000022;
    words[2] = 32'h00000033; words[3] = 32'h00000044;
    words[4] = 32'h00000055;
    for (int i = 0; i < 4; i++) begin
      bus.ihit = 1; bus.instr_in = words[i]; bus.npc_in = 32'h100 + 32'(4 * i);
      tick();
    end
    bus.instr_in = words[4]; bus.npc_in = 32'h110;
    #1;
    vectors++; if (bus.full !== 1'b1 || bus.count !== 3'd4) begin errors++; $display("FAIL full_flag got %b/%0d exp 1/4", bus.full, bus.count); end
    vectors++; if (bus.accept !== 1'b0) begin errors++; $display("FAIL full_refuse got %b exp 0", bus.accept); end
    bus.pop = 1;
    #1;
    vectors++; if (bus.accept !== 1'b1) begin errors++; $display("FAIL full_pushpop_accept got %b exp 1", bus.accept); end
    vectors++; if (bus.instr !== words[0] || bus.npc !== 32'h100) begin errors++; $display("FAIL full_head0 got %h/%h exp %h/00000100", bus.instr, bus.npc, words[0]); end
    tick();
    bus.ihit = 0;
    #1;
    vectors++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_pushpop_count got %0d exp 4", bus.count); end
    for (int i = 1; i < 5; i++) begin
      vectors++; if (bus.instr !== words[i] || bus.npc !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL full_order%0d got %h/%h exp %h", i, bus.instr, bus.npc, words[i]); end
      tick();
    end
    idle();
    #1;
    vectors++; if (bus.count !== 3'd0 || bus.valid !== 1'b0) begin errors++; $display("FAIL full_drained got %0d/%b exp 0/0", bus.count, bus.valid); end
  endtask

  task automatic test_imm();
    bus.ihit = 1; bus.instr_in = 32'h3C01FFFF; bus.npc_in = 32'h20;
    tick();
    idle();
    bus.ext_op = 1;
    #1;
    vectors++; if (bus.imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL imm_sext got %h exp ffffffff", bus.imm); end
    vectors++; if (bus.lui !== 32'hFFFF0000) begin errors++; $display("FAIL lui got %h exp ffff0000", bus.lui); end
    vectors++; if (bus.shamt !== 32'h1F || bus.rd !== 5'd31) begin errors++; $display("FAIL imm_shamt_rd got %h/%0d exp 1f/31", bus.shamt, bus.rd); end
    bus.ext_op = 0;
    #1;
    vectors++; if (bus.imm !== 32'h0000FFFF) begin errors++; $display("FAIL imm_zext got %h exp 0000ffff", bus.imm); end
    vectors++; if (bus.lui !== 32'hFFFF0000) begin errors++; $display("FAIL lui_zext got %h exp ffff0000", bus.lui); end
    bus.ext_op = 1; bus.pop = 1;
    tick();
    idle();
  endtask

  task automatic test_halt();
    bus.ihit = 1; bus.instr_in = 32'hFC000000; bus.npc_in = 32'h30;
    #1;
    vectors++; if (bus.accept !== 1'b1) begin errors++; $display("FAIL halt_push got %b exp 1", bus.accept); end
    tick();
    bus.instr_in = 32'h20010001; bus.npc_in = 32'h34;
    #1;
    vectors++; if (bus.accept !== 1'b0) begin errors++; $display("FAIL halt_block got %b exp 0", bus.accept); end
    vectors++; if (bus.halt !== 1'b1) begin errors++; $display("FAIL halt_flag got %b exp 1", bus.halt); end
    tick();
    #1;
    vectors++; if (bus.count !== 3'd1 || bus.accept !== 1'b0) begin errors++; $display("FAIL halt_sticky got %0d/%b exp 1/0", bus.count, bus.accept); end
    bus.flush = 1;
    tick();
    bus.flush = 0;
    #1;
    vectors++; if (bus.count !== 3'd0 || bus.halt !== 1'b0) begin errors++; $display("FAIL halt_flush got %0d/%b exp 0/0", bus.count, bus.halt); end
    vectors++; if (bus.accept !== 1'b1) begin errors++; $display("FAIL halt_reaccept got %b exp 1", bus.accept); end
    tick();
    idle();
    #1;
    vectors++; if (bus.count !== 3'd1 || bus.instr !== 32'h20010001) begin errors++; $display("FAIL halt_after got %0d/%h exp 1/20010001", bus.count, bus.instr); end
    bus.pop = 1;
    tick();
    idle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      bus.ihit = 1; bus.instr_in = 32'h00000100 + 32'(i); bus.npc_in = 32'h40 + 32'(4 * i);
      tick();
    end
    bus.ihit = 1; bus.pop = 1; bus.flush = 1; bus.instr_in = 32'h00000200;
    #1;
    vectors++; if (bus.count !== 3'd3 || bus.accept !== 1'b0) begin errors++; $display("FAIL flush_pre got %0d/%b exp 3/0", bus.count, bus.accept); end
    tick();
    idle();
    #1;
    vectors++; if (bus.valid !== 1'b0 || bus.count !== 3'd0) begin errors++; $display("FAIL flush_post got %b/%0d exp 0/0", bus.valid, bus.count); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      bus.ihit = 1; bus.instr_in = 32'h00000300 + 32'(i); bus.npc_in = 32'h60;
      tick();
    end
    idle();
    #1;
    vectors++; if (bus.count !== 3'd2) begin errors++; $display("FAIL arst_pre got %0d exp 2", bus.count); end
    RST = 1;
    #1;
    vectors++; if (bus.valid !== 1'b0 || bus.count !== 3'd0 || bus.instr !== 32'h0 || bus.npc !== 32'h0) begin errors++; $display("FAIL arst_clear got %b/%0d/%h/%h exp 0", bus.valid, bus.count, bus.instr, bus.npc); end
    tick();
    RST = 0;
    tick();
  endtask

  task automatic test_bypass();
    bus.ihit = 1; bus.pop = 1; bus.instr_in = 32'h00221820; bus.npc_in = 32'h80;
    #1;
`ifdef FDQ_BYPASS_EN
    vectors++; if (bus.valid !== 1'b1 || bus.rd !== 5'd3 || bus.rt !== 5'd2 || bus.rs !== 5'd1) begin errors++; $display("FAIL byp_fields got %b/%0d/%0d/%0d exp 1/3/2/1", bus.valid, bus.rd, bus.rt, bus.rs); end
    tick();
    idle();
    #1;
    vectors++; if (bus.count !== 3'd0 || bus.valid !== 1'b0) begin errors++; $display("FAIL byp_consumed got %0d/%b exp 0/0", bus.count, bus.valid); end
`else
    vectors++; if (bus.valid !== 1'b0 || bus.rd !== 5'd0) begin errors++; $display("FAIL nobyp_same got %b/%0d exp 0/0", bus.valid, bus.rd); end
    tick();
    idle();
    #1;
    vectors++; if (bus.count !== 3'd1 || bus.rd !== 5'd3 || bus.rt !== 5'd2 || bus.rs !== 5'd1) begin errors++; $display("FAIL nobyp_next got %0d/%0d/%0d/%0d exp 1/3/2/1", bus.count, bus.rd, bus.rt, bus.rs); end
    bus.pop = 1;
    tick();
    idle();
`endif
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_full();
    test_imm();
    test_halt();
    test_flush();
    test_async_reset();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
